// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates a MEM-stage request, performs a read,
// read-modify-write or direct write against a word memory, then pulses a response.
module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_we,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RESP
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        we_q;

    logic        req_fault;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_fmt;
    logic [31:0] store_merge;

    assign req_ready   = (state == IDLE);
    assign mem_address = {2'b00, addr_q[31:2]};

    // Reject illegal width codes, misaligned halfword/word and out-of-range words.
    always_comb begin
        req_fault = 1'b0;
        if (req_we) begin
            if (req_funct3 >= 3'b011)
                req_fault = 1'b1;
        end else begin
            if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
                req_fault = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_fault = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))
            req_fault = 1'b1;
    end

    always_comb begin
        lane_byte = mem_data_out[7:0];
        case (addr_q[1:0])
            2'd0:    lane_byte = mem_data_out[7:0];
            2'd1:    lane_byte = mem_data_out[15:8];
            2'd2:    lane_byte = mem_data_out[23:16];
            default: lane_byte = mem_data_out[31:24];
        endcase
        lane_half = addr_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_fmt = {24'h0, lane_byte};
            3'b101:  load_fmt = {16'h0, lane_half};
            default: load_fmt = mem_data_out;
        endcase
    end

    // Little-endian lane insert of the store data into the fetched word.
    always_comb begin
        store_merge = mem_data_out;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    store_merge[7:0]   = wdata_q[7:0];
                2'd1:    store_merge[15:8]  = wdata_q[7:0];
                2'd2:    store_merge[23:16] = wdata_q[7:0];
                default: store_merge[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            store_merge[31:16] = wdata_q;
        end else begin
            store_merge[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 16'h0;
            funct3_q    <= 3'b000;
            we_q        <= 1'b0;
            mem_we      <= 1'b0;
            mem_data_in <= 32'h0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0;
            resp_fault  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata[15:0];
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        if (req_fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && req_funct3[1:0] == 2'b10) begin
                            mem_data_in <= req_wdata;
                            mem_we      <= 1'b1;
                            state       <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= RD_WAIT;
                RD_WAIT: begin
                    if (we_q) begin
                        mem_data_in <= store_merge;
                        mem_we      <= 1'b1;
                        state       <= WR;
                    end else begin
                        resp_rdata <= load_fmt;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'h0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_WORDS, 32, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  access request from MEM stage.
REQ-005 SHALL have port: req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RV32I width/sign code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_rdata  output  32  load result, extended.
REQ-012 SHALL have port: resp_fault  output  1  request rejected (misaligned, illegal funct3, out of range).
REQ-013 SHALL have port: mem_address  output  32  word index to data memory.
REQ-014 SHALL have port: mem_data_in  output  32  write word to data memory.
REQ-015 SHALL have port: mem_we  output  1  data memory write enable.
REQ-016 SHALL have port: mem_data_out  input  32  data memory read word, valid the cycle after a read is presented.

Function
REQ-017 SHALL implement FSM states IDLE, RD, RD_WAIT, WR, RESP.
REQ-018 SHALL assert req_ready only in IDLE; request accepted on a rising edge with req_valid & req_ready; addr, we, funct3, wdata latched then.
REQ-019 SHALL flag fault when: load funct3 in {011,110,111}; store funct3 >= 011; halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= MEM_WORDS.
REQ-020 SHALL on accept go: fault -> RESP; SW -> WR; all loads, SB, SH -> RD.
REQ-021 SHALL transition RD -> RD_WAIT; RD_WAIT -> RESP for loads, -> WR for SB/SH; WR -> RESP; RESP -> IDLE.
REQ-022 SHALL drive mem_address = {2'b00, latched addr[31:2]} in all states (0 after reset until first accept).
REQ-023 SHALL assert mem_we only in WR, for exactly one cycle per store; mem_we = 0 in every other state and on fault.
REQ-024 SHALL, in RD_WAIT of SB/SH, merge wdata lane into mem_data_out (little-endian: byte n = bits 8n+7:8n, n = addr[1:0]; half at addr[1]) and register result as mem_data_in; SW drives wdata unchanged.
REQ-025 SHALL format loads in RD_WAIT: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; register into resp_rdata.
REQ-026 SHALL assert resp_valid for exactly one cycle in RESP; no backpressure.
REQ-027 SHALL set resp_rdata = 0 for stores and faults; resp_fault = 1 only in RESP of a faulted request; both 0 outside RESP.
REQ-028 SHALL meet latency (accept edge to resp_valid cycle): fault 1, SW 2, loads 3, SB/SH 4.
REQ-029 SHALL ignore req_valid while not in IDLE; a new request may be accepted on the edge leaving RESP only if back in IDLE, giving one idle cycle between accesses.

Reset
REQ-030 SHALL on rst = 1 immediately (asynchronously) enter IDLE, clear latched request, mem_we = 0, mem_address = 0, mem_data_in = 0, resp_valid = 0, resp_rdata = 0, resp_fault = 0, req_ready = 1 after release.
REQ-031 SHALL abandon any in-flight access on reset with no response; a store reset before or during WR SHALL NOT be retried.

Verification
REQ-032 SHALL pass: word 3 = 0x8899AABB, LB addr 0x0F -> resp_rdata 0xFFFFFF88, resp_valid 3 cycles after accept, mem_we never 1.
REQ-033 SHALL pass: word 3 = 0x8899AABB, LBU addr 0x0E -> 0x00000099; LHU addr 0x0C -> 0x0000AABB.
REQ-034 SHALL pass: word 3 = 0x8899AABB, SH wdata 0xFFFF1234 addr 0x0E -> one mem_we pulse, mem_data_in 0x1234AABB, resp_valid 4 cycles after accept, resp_rdata 0.
REQ-035 SHALL pass: LW addr 0x0D, then SW addr 0x80, then load funct3 011 -> each resp_fault 1 one cycle after accept, mem_we stays 0.
REQ-036 SHALL pass: SW 0xDEADBEEF addr 0x04 -> mem_we high cycle 1, resp_valid cycle 2; LW addr 0x04 -> 0xDEADBEEF.
REQ-037 SHALL pass: SB accepted, rst pulsed in RD_WAIT -> mem_we 0, no resp_valid, req_ready 1 after release, word unchanged.
